// File: rtl/core_pkg.sv
// Shared core definitions for the writeback stage: datapath widths and the
// writeback source encoding used by the grant mux.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;   // must equal $clog2(NREGS)

    // Which execute unit owns the write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2,
        WB_MDU  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin arbiter (req[0]=LSU, req[1]=MDU) with an
// external override that blocks both grants (the ALU cannot be stalled).
module wb_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       ovr,
    output logic [1:0] gnt
);

    // 0 = requester 0 was granted last, 1 = requester 1 was granted last.
    // Reset to 1 so requester 0 wins the first contested cycle.
    logic rr_last;

    // Grant: override wins, a lone requester wins, contention goes to the
    // requester that was not granted last. Depends only on req/ovr/rr_last.
    always_comb begin
        gnt = 2'b00;
        if (!ovr) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the last granted requester; idle or overridden cycles keep it.
    always_ff @(posedge clk) begin
        if (rst)
            rr_last <= 1'b1;
        else if (|gnt)
            rr_last <= gnt[1];
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: merges ALU / LSU / MDU results onto the single
// register-file write port and keeps the long-latency pending scoreboard
// that the issue stage uses to stall on RAW/WAW hazards.
module regfile_wb_ctrl
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int NREGS  = core_pkg::NREGS,
    parameter int ADDR_W = core_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    // issue stage
    input  logic              iss_valid,
    input  logic              iss_long,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    output logic              iss_ready,
    // ALU, fixed latency, no back-pressure
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    // LSU result
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              lsu_ready,
    // MDU result
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]   mdu_data,
    output logic              mdu_ready,
    // register file write port
    output logic              we,
    output logic [ADDR_W-1:0] write_addr,
    output logic [XLEN-1:0]   result,
    output logic [NREGS-1:0]  pending
);

    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_set;
    logic [NREGS-1:0]  pend_clr;
    logic [NREGS-1:0]  pend_nxt;
    logic [1:0]        gnt;
    wb_src_e           src;
    logic [ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic              long_gnt;

    assign pending = pend_q;

    // Stall on any operand or destination with a long write in flight. Uses
    // the pre-clear value, so a register retiring this cycle still stalls
    // once; this also guarantees set and clear never hit the same register.
    assign iss_ready = !(pend_q[iss_rs1] | pend_q[iss_rs2] | pend_q[iss_rd]);

    wb_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({mdu_valid, lsu_valid}),
        .ovr (alu_valid),
        .gnt (gnt)
    );

    assign lsu_ready = gnt[0];
    assign mdu_ready = gnt[1];

    // Grant mux: the ALU owns the port whenever valid, else the arbiter winner.
    always_comb begin
        src      = WB_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (alu_valid) begin
            src      = WB_ALU;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end else if (gnt[0]) begin
            src      = WB_LSU;
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end else if (gnt[1]) begin
            src      = WB_MDU;
            sel_rd   = mdu_rd;
            sel_data = mdu_data;
        end
    end

    assign long_gnt = (src == WB_LSU) || (src == WB_MDU);

    // Registered write port; an x0 destination is consumed without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we         <= 1'b0;
            write_addr <= '0;
            result     <= '0;
        end else begin
            we <= (src != WB_NONE) && (sel_rd != '0);
            if (src != WB_NONE) begin
                write_addr <= sel_rd;
                result     <= sel_data;
            end
        end
    end

    // Scoreboard next state: set on accepted long issue, clear on long grant;
    // bit 0 is forced low so x0 never stalls anything.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (iss_valid && iss_ready && iss_long)
            pend_set[iss_rd] = 1'b1;
        if (long_gnt)
            pend_clr[sel_rd] = 1'b1;
        pend_nxt    = (pend_q & ~pend_clr) | pend_set;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst)
            pend_q <= '0;
        else
            pend_q <= pend_nxt;
    end

    // Protocol checks on the producers; the RTL does not recover from these.
    a_alu_not_pending: assert property (@(posedge clk) disable iff (rst)
        alu_valid |-> !pend_q[alu_rd]);
    a_lsu_was_pending: assert property (@(posedge clk) disable iff (rst)
        (lsu_valid && lsu_ready && lsu_rd != '0) |-> pend_q[lsu_rd]);
    a_mdu_was_pending: assert property (@(posedge clk) disable iff (rst)
        (mdu_valid && mdu_ready && mdu_rd != '0) |-> pend_q[mdu_rd]);
    a_lsu_stable: assert property (@(posedge clk) disable iff (rst)
        (lsu_valid && !lsu_ready) |=> (lsu_valid && $stable(lsu_rd) && $stable(lsu_data)));
    a_mdu_stable: assert property (@(posedge clk) disable iff (rst)
        (mdu_valid && !mdu_ready) |=> (mdu_valid && $stable(mdu_rd) && $stable(mdu_data)));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed stimulus, a behavioural
// model compared on every falling edge, plus literal expectations.
module tb_regfile_wb_ctrl;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            iss_valid, iss_long, iss_ready;
    logic [AW-1:0]   iss_rd, iss_rs1, iss_rs2;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid, lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            mdu_valid, mdu_ready;
    logic [AW-1:0]   mdu_rd;
    logic [XLEN-1:0] mdu_data;
    logic            we;
    logic [AW-1:0]   write_addr;
    logic [XLEN-1:0] result;
    logic [NREGS-1:0] pending;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_ready(iss_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .we(we), .write_addr(write_addr), .result(result), .pending(pending)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit [NREGS-1:0] m_pend;
    bit             m_we;
    bit [AW-1:0]    m_addr;
    bit [XLEN-1:0]  m_res;
    bit             m_lsu_turn;   // LSU wins the next LSU/MDU contest
    bit             started = 0;
    int             m_g;
    bit             m_ir;

    function automatic bit f_iss_ready();
        return !(m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
    endfunction

    // 0 = no long grant, 1 = LSU, 2 = MDU
    function automatic int f_grant();
        if (alu_valid) return 0;
        if (lsu_valid && mdu_valid) return m_lsu_turn ? 1 : 2;
        if (lsu_valid) return 1;
        if (mdu_valid) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started    = 1;
            m_pend     = '0;
            m_we       = 0;
            m_addr     = '0;
            m_res      = '0;
            m_lsu_turn = 1;
        end else begin
            m_g  = f_grant();
            m_ir = f_iss_ready();
            if (alu_valid) begin
                m_we = (alu_rd != 0); m_addr = alu_rd; m_res = alu_data;
            end else if (m_g == 1) begin
                m_we = (lsu_rd != 0); m_addr = lsu_rd; m_res = lsu_data;
                m_pend[lsu_rd] = 0; m_lsu_turn = 0;
            end else if (m_g == 2) begin
                m_we = (mdu_rd != 0); m_addr = mdu_rd; m_res = mdu_data;
                m_pend[mdu_rd] = 0; m_lsu_turn = 1;
            end else begin
                m_we = 0;
            end
            if (iss_valid && m_ir && iss_long && iss_rd != 0) m_pend[iss_rd] = 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_iss_ready", iss_ready, f_iss_ready());
            chk("m_lsu_ready", lsu_ready, f_grant() == 1);
            chk("m_mdu_ready", mdu_ready, f_grant() == 2);
            chk("m_we", we, m_we);
            chk("m_pending", pending, m_pend);
            if (m_we) begin
                chk("m_write_addr", write_addr, m_addr);
                chk("m_result", result, m_res);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_long = 0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        mdu_valid = 0; mdu_rd = '0; mdu_data = '0;
    endtask

    task automatic issue_long(input logic [AW-1:0] rd);
        iss_valid = 1; iss_long = 1; iss_rd = rd; iss_rs1 = '0; iss_rs2 = '0;
        tick();
        iss_valid = 0; iss_long = 0; iss_rd = '0;
    endtask

    int lq[3] = '{10, 12, 14};
    int mq[3] = '{11, 13, 15};
    int exp_g[7] = '{1, 2, 0, 1, 2, 1, 2};
    int li, mi, got;

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        // reset state
        chk("rst_we", we, 0);
        chk("rst_pending", pending, 0);
        chk("rst_iss_ready", iss_ready, 1);

        // ALU write, then hold of address/data on an idle cycle
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 0;
        chk("alu_we", we, 1);
        chk("alu_addr", write_addr, 5);
        chk("alu_result", result, 32'hDEADBEEF);
        tick();
        chk("idle_we", we, 0);
        chk("idle_addr_hold", write_addr, 5);
        chk("idle_result_hold", result, 32'hDEADBEEF);

        // RAW hazard on a long destination, cleared by an LSU result
        iss_valid = 1; iss_long = 1; iss_rd = 7;
        #1 chk("iss7_ready", iss_ready, 1);
        tick();
        iss_long = 0; iss_rd = 8; iss_rs1 = 7;
        #1;
        chk("pend7_set", pending[7], 1);
        chk("raw_stall", iss_ready, 0);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h11;
        #1;
        chk("lsu7_ready", lsu_ready, 1);
        chk("stall_during_clear", iss_ready, 0);
        tick();
        lsu_valid = 0;
        chk("pend7_clr", pending[7], 0);
        chk("lsu7_we", we, 1);
        chk("lsu7_addr", write_addr, 7);
        chk("lsu7_result", result, 32'h11);
        chk("raw_released", iss_ready, 1);
        idle_inputs();

        // reset mid-stream drops an accepted ALU result and clears pending
        issue_long(20);
        chk("pend20_set", pending[20], 1);
        rst = 1; alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        tick();
        rst = 0; alu_valid = 0;
        chk("midrst_pending", pending, 0);
        chk("midrst_we", we, 0);

        // round robin LSU/MDU with an ALU cycle inserted
        for (int r = 10; r <= 15; r++) issue_long(r[AW-1:0]);
        chk("rr_pending", pending, 32'h0000_FC00);
        li = 0; mi = 0;
        for (int i = 0; i < 7; i++) begin
            lsu_valid = (li < 3); lsu_rd = (li < 3) ? lq[li][AW-1:0] : '0;
            lsu_data  = 32'h100 + 32'(lsu_rd);
            mdu_valid = (mi < 3); mdu_rd = (mi < 3) ? mq[mi][AW-1:0] : '0;
            mdu_data  = 32'h200 + 32'(mdu_rd);
            alu_valid = (i == 2); alu_rd = 1; alu_data = 32'hA5A50001;
            #1;
            got = lsu_ready ? 1 : (mdu_ready ? 2 : 0);
            chk($sformatf("rr_grant%0d", i), got, exp_g[i]);
            if (lsu_ready) li++;
            if (mdu_ready) mi++;
            tick();
            if (i == 2) begin
                chk("rr_alu_addr", write_addr, 1);
                chk("rr_alu_result", result, 32'hA5A50001);
            end
        end
        idle_inputs();
        chk("rr_drained", pending, 0);

        // x0: result consumed without a write, long issue to x0 never pends
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hFFFFFFFF;
        #1 chk("x0_lsu_ready", lsu_ready, 1);
        tick();
        lsu_valid = 0;
        chk("x0_we", we, 0);
        issue_long(0);
        chk("x0_pending", pending, 0);

        // same-cycle set of x3 and clear of x9
        issue_long(9);
        iss_valid = 1; iss_long = 1; iss_rd = 3;
        mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
        #1 chk("sc_mdu_ready", mdu_ready, 1);
        tick();
        idle_inputs();
        chk("sc_pend3", pending[3], 1);
        chk("sc_pend9", pending[9], 0);
        chk("sc_we", we, 1);
        chk("sc_addr", write_addr, 9);
        chk("sc_result", result, 32'h99);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
